// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian phase scheduler.
// Holds the phase state encoding, timer/crosswalk sizing and the
// index-to-one-hot lamp decode used by the scheduler.
package ped_pkg;

    localparam int TMR_W  = 5;
    localparam int NUM_XW = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WALK    = 3'd2,
        CLEAR   = 3'd3,
        RELEASE = 3'd4
    } ped_state_t;

    // Turn a crosswalk index into the matching lamp bit
    function automatic logic [NUM_XW-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_XW-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ped_rr_arbiter.sv
// Combinational 4-way round-robin arbiter for crosswalk requests.
// Grants the first pending crosswalk at or after rr_ptr, wrapping D back to A.
module ped_rr_arbiter
    import ped_pkg::*;
(
    input  logic [NUM_XW-1:0] pending,
    input  logic [1:0]        rr_ptr,
    output logic [1:0]        grant_idx,
    output logic              grant_valid
);

    // Scan from the farthest offset down so the nearest pending crosswalk wins last
    always_comb begin
        logic [1:0] cand;
        cand        = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = NUM_XW - 1; i >= 0; i--) begin
            cand = rr_ptr + 2'(i);
            if (pending[cand]) begin
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_phase_scheduler.sv
// Exclusive pedestrian phase scheduler for a four-way intersection.
// Latches crosswalk requests, picks one round-robin, parks traffic in all-red
// through the hold handshake, then times walk and clearance on sec_tick and
// enforces a vehicle gap before the next pedestrian phase.
// Optional feature: define PED_CHIRP_EN to add the audible chirp output.
module ped_phase_scheduler
    import ped_pkg::*;
#(
    parameter int unsigned WALK_TIME  = 20,
    parameter int unsigned CLEAR_TIME = 5,
    parameter int unsigned GAP_TIME   = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic [NUM_XW-1:0] ped_btn,
    input  logic              hold_ack,
    output logic              hold_req,
    output logic [NUM_XW-1:0] walk,
    output logic [NUM_XW-1:0] flash,
    output logic [NUM_XW-1:0] ped_pending,
    output logic [1:0]        grant_idx
`ifdef PED_CHIRP_EN
    ,
    output logic              chirp
`endif
);

    localparam logic [TMR_W-1:0] WALK_T  = TMR_W'(WALK_TIME);
    localparam logic [TMR_W-1:0] CLEAR_T = TMR_W'(CLEAR_TIME);
    localparam logic [TMR_W-1:0] GAP_T   = TMR_W'(GAP_TIME);
    localparam logic [TMR_W-1:0] ONE_T   = TMR_W'(1);

    ped_state_t        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [NUM_XW-1:0] pending_q, pending_d;
    logic              hold_req_q, hold_req_d;
    logic [NUM_XW-1:0] walk_q, walk_d;
    logic [NUM_XW-1:0] flash_q, flash_d;
    logic [NUM_XW-1:0] grant_mask;
    logic [NUM_XW-1:0] btn_set;
    logic [1:0]        arb_idx;
    logic              arb_valid;
`ifdef PED_CHIRP_EN
    logic              chirp_q, chirp_d;
`endif

    ped_rr_arbiter u_arb (
        .pending     (pending_q),
        .rr_ptr      (rr_ptr_q),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Next-state, timer, request latch and registered-output decode
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        grant_mask = idx_to_onehot(grant_q);
        btn_set    = ped_btn;
        if (state_q == WALK || state_q == CLEAR) begin
            btn_set = ped_btn & ~grant_mask;
        end
        pending_d = pending_q | btn_set;

        case (state_q)
            IDLE: begin
                if (sec_tick && timer_q != '0) begin
                    timer_d = timer_q - ONE_T;
                end
                if (arb_valid && timer_q == '0) begin
                    state_d = REQ;
                    grant_d = arb_idx;
                end
            end
            REQ: begin
                if (hold_ack) begin
                    state_d   = WALK;
                    timer_d   = WALK_T;
                    rr_ptr_d  = grant_q + 2'd1;
                    pending_d = pending_d & ~grant_mask;
                end
            end
            WALK: begin
                if (!hold_ack) begin
                    state_d   = IDLE;
                    timer_d   = GAP_T;
                    pending_d = pending_d | grant_mask;
                end else if (sec_tick) begin
                    if (timer_q == ONE_T) begin
                        state_d = CLEAR;
                        timer_d = CLEAR_T;
                    end else if (timer_q > ONE_T) begin
                        timer_d = timer_q - ONE_T;
                    end
                end
            end
            CLEAR: begin
                if (!hold_ack) begin
                    state_d   = IDLE;
                    timer_d   = GAP_T;
                    pending_d = pending_d | grant_mask;
                end else if (sec_tick) begin
                    if (timer_q == ONE_T) begin
                        state_d = RELEASE;
                    end else if (timer_q > ONE_T) begin
                        timer_d = timer_q - ONE_T;
                    end
                end
            end
            RELEASE: begin
                if (!hold_ack) begin
                    state_d = IDLE;
                    timer_d = GAP_T;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_req_d = (state_d == REQ) || (state_d == WALK) || (state_d == CLEAR);
        walk_d     = (state_d == WALK)  ? idx_to_onehot(grant_d) : '0;
        flash_d    = (state_d == CLEAR) ? idx_to_onehot(grant_d) : '0;
`ifdef PED_CHIRP_EN
        chirp_d = 1'b0;
        if (state_d == WALK) begin
            chirp_d = (state_q == WALK && sec_tick) ? ~chirp_q : chirp_q;
        end
`endif
    end

    // Phase state, timer, arbitration pointer and Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            pending_q  <= '0;
            hold_req_q <= 1'b0;
            walk_q     <= '0;
            flash_q    <= '0;
`ifdef PED_CHIRP_EN
            chirp_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            pending_q  <= pending_d;
            hold_req_q <= hold_req_d;
            walk_q     <= walk_d;
            flash_q    <= flash_d;
`ifdef PED_CHIRP_EN
            chirp_q    <= chirp_d;
`endif
        end
    end

    assign hold_req    = hold_req_q;
    assign walk        = walk_q;
    assign flash       = flash_q;
    assign ped_pending = pending_q;
    assign grant_idx   = grant_q;
`ifdef PED_CHIRP_EN
    assign chirp       = chirp_q;
`endif

endmodule

// File: tb/tb_ped_phase_scheduler.sv
// Self-checking bench for ped_phase_scheduler.
// Expected grants are queued when requests are pressed and popped by a
// monitor each time a walk lamp lights; scenario tasks check the rest inline.
module tb_ped_phase_scheduler;

    localparam int WALK_T  = 20;
    localparam int CLEAR_T = 5;
    localparam int GAP_T   = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [3:0] ped_btn;
    logic       hold_ack;
    logic       hold_req;
    logic [3:0] walk;
    logic [3:0] flash;
    logic [3:0] ped_pending;
    logic [1:0] grant_idx;
`ifdef PED_CHIRP_EN
    logic       chirp;
    logic       chirp_prev = 1'b0;
    int         chirp_edges = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    logic [3:0] walk_prev = 4'b0;

    ped_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .ped_btn     (ped_btn),
        .hold_ack    (hold_ack),
        .hold_req    (hold_req),
        .walk        (walk),
        .flash       (flash),
        .ped_pending (ped_pending),
        .grant_idx   (grant_idx)
`ifdef PED_CHIRP_EN
        ,
        .chirp       (chirp)
`endif
    );

    // Free-running system clock
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Scoreboard: every new walk lamp must match the next queued grant
    always @(negedge clk) begin
        if (!rst && walk !== 4'b0 && walk_prev === 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_walk actual=%b required=none", walk);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (walk !== oh(e) || grant_idx !== 2'(e)) begin
                    errors++;
                    $display("[TB] FAIL sb_grant actual walk=%b idx=%0d required walk=%b idx=%0d",
                             walk, grant_idx, oh(e), e);
                end
            end
        end
        walk_prev <= walk;
    end

`ifdef PED_CHIRP_EN
    // Count every chirp level change
    always @(negedge clk) begin
        if (chirp !== chirp_prev) chirp_edges <= chirp_edges + 1;
        chirp_prev <= chirp;
    end
`endif

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic sec(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            @(negedge clk);
            sec_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [3:0] b);
        ped_btn = b;
        cycle(1);
        ped_btn = 4'b0;
    endtask

    // Tick seconds until hold_req rises, then acknowledge and enter WALK
    task automatic start_walk(input int g);
        int n;
        n = 0;
        while (hold_req !== 1'b1 && n < 100) begin
            sec(1);
            n++;
        end
        checks++;
        if (hold_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_hold_req actual=%b required=1 (timeout)", hold_req);
        end
        checks++;
        if (grant_idx !== 2'(g)) begin
            errors++;
            $display("[TB] FAIL req_grant actual=%0d required=%0d", grant_idx, g);
        end
        hold_ack = 1'b1;
        cycle(1);
        checks++;
        if (walk !== oh(g) || flash !== 4'b0 || hold_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL walk_entry actual walk=%b flash=%b hold=%b required walk=%b flash=0000 hold=1",
                     walk, flash, hold_req, oh(g));
        end
    endtask

    // Run the remaining walk and clearance seconds, then release the hold
    task automatic run_phase(input int g, input int done);
        sec(WALK_T - 1 - done);
        checks++;
        if (walk !== oh(g) || flash !== 4'b0) begin
            errors++;
            $display("[TB] FAIL walk_last_sec actual walk=%b flash=%b required walk=%b flash=0000",
                     walk, flash, oh(g));
        end
        sec(1);
        checks++;
        if (walk !== 4'b0 || flash !== oh(g) || hold_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_entry actual walk=%b flash=%b hold=%b required walk=0000 flash=%b hold=1",
                     walk, flash, hold_req, oh(g));
        end
        sec(CLEAR_T - 1);
        checks++;
        if (flash !== oh(g) || hold_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_last_sec actual flash=%b hold=%b required flash=%b hold=1",
                     flash, hold_req, oh(g));
        end
        sec(1);
        checks++;
        if (flash !== 4'b0 || walk !== 4'b0 || hold_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release actual flash=%b walk=%b hold=%b required 0000 0000 0",
                     flash, walk, hold_req);
        end
        hold_ack = 1'b0;
        cycle(1);
        checks++;
        if (hold_req !== 1'b0 || walk !== 4'b0 || flash !== 4'b0) begin
            errors++;
            $display("[TB] FAIL back_to_idle actual hold=%b walk=%b flash=%b required 0 0000 0000",
                     hold_req, walk, flash);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sec_tick = 1'b0; ped_btn = 4'b0; hold_ack = 1'b0;
        cycle(3);
        rst = 1'b0;
        cycle(1);
        checks++;
        if (hold_req !== 1'b0 || walk !== 4'b0 || flash !== 4'b0 ||
            ped_pending !== 4'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state actual hold=%b walk=%b flash=%b pend=%b idx=%0d required all 0",
                     hold_req, walk, flash, ped_pending, grant_idx);
        end
    endtask

    task automatic test_two_requests();
        press(4'b1001);
        checks++;
        if (ped_pending !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL two_pending actual=%b required=1001", ped_pending);
        end
        exp_q.push_back(0);
        exp_q.push_back(3);
        start_walk(0);
        run_phase(0, 0);
        sec(GAP_T - 1);
        checks++;
        if (hold_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_hold_early actual=%b required=0", hold_req);
        end
        sec(1);
        checks++;
        if (hold_req !== 1'b1 || grant_idx !== 2'd3) begin
            errors++;
            $display("[TB] FAIL gap_hold_rise actual hold=%b idx=%0d required hold=1 idx=3",
                     hold_req, grant_idx);
        end
        start_walk(3);
        run_phase(3, 0);
    endtask

    task automatic test_round_robin();
        logic [3:0] rem;
        press(4'b1111);
        rem = 4'b1111;
        checks++;
        if (ped_pending !== rem) begin
            errors++;
            $display("[TB] FAIL rr_pending actual=%b required=%b", ped_pending, rem);
        end
        for (int g = 0; g < 4; g++) exp_q.push_back(g);
        for (int g = 0; g < 4; g++) begin
            start_walk(g);
            rem = rem & ~oh(g);
            checks++;
            if (ped_pending !== rem) begin
                errors++;
                $display("[TB] FAIL rr_remaining actual=%b required=%b", ped_pending, rem);
            end
            run_phase(g, 0);
        end
    endtask

    task automatic test_mask_during_walk();
        press(4'b0010);
        exp_q.push_back(1);
        start_walk(1);
        press(4'b0110);
        checks++;
        if (ped_pending !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL mask_granted_bit actual=%b required=0100", ped_pending);
        end
        run_phase(1, 0);
        exp_q.push_back(2);
        start_walk(2);
        checks++;
        if (ped_pending !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mask_c_served actual=%b required=0000", ped_pending);
        end
        run_phase(2, 0);
    endtask

    task automatic test_single();
        int base;
        sec(GAP_T);
        press(4'b0100);
        checks++;
        if (ped_pending !== 4'b0100 || hold_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latch actual pend=%b hold=%b required pend=0100 hold=0",
                     ped_pending, hold_req);
        end
        cycle(1);
        checks++;
        if (hold_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_hold_rise actual=%b required=1", hold_req);
        end
        exp_q.push_back(2);
`ifdef PED_CHIRP_EN
        base = chirp_edges;
`else
        base = 0;
`endif
        start_walk(2);
        run_phase(2, 0);
        checks++;
        if (ped_pending !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_idle_pending actual=%b required=0000", ped_pending);
        end
`ifdef PED_CHIRP_EN
        checks++;
        if (chirp_edges - base !== WALK_T || chirp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chirp_toggles actual=%0d level=%b required=%0d level=0",
                     chirp_edges - base, chirp, WALK_T);
        end
`else
        if (base != 0) $display("[TB] note: unexpected chirp base %0d", base);
`endif
    endtask

    task automatic test_abort();
        press(4'b0001);
        exp_q.push_back(0);
        start_walk(0);
        sec(7);
        checks++;
        if (walk !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_pre_walk actual=%b required=0001", walk);
        end
        hold_ack = 1'b0;
        cycle(1);
        checks++;
        if (walk !== 4'b0 || flash !== 4'b0 || hold_req !== 1'b0 || ped_pending !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_drop actual walk=%b flash=%b hold=%b pend=%b required 0000 0000 0 0001",
                     walk, flash, hold_req, ped_pending);
        end
        sec(GAP_T - 1);
        checks++;
        if (hold_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_gap_early actual=%b required=0", hold_req);
        end
        exp_q.push_back(0);
        sec(1);
        checks++;
        if (hold_req !== 1'b1 || grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL abort_gap_rise actual hold=%b idx=%0d required hold=1 idx=0",
                     hold_req, grant_idx);
        end
        start_walk(0);
        run_phase(0, 0);
    endtask

    task automatic test_reset_mid_phase();
        press(4'b1000);
        exp_q.push_back(3);
        start_walk(3);
        press(4'b0010);
        sec(WALK_T);
        checks++;
        if (flash !== 4'b1000 || ped_pending !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL pre_reset actual flash=%b pend=%b required flash=1000 pend=0010",
                     flash, ped_pending);
        end
        rst = 1'b1;
        cycle(1);
        checks++;
        if (hold_req !== 1'b0 || walk !== 4'b0 || flash !== 4'b0 ||
            ped_pending !== 4'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset actual hold=%b walk=%b flash=%b pend=%b idx=%0d required all 0",
                     hold_req, walk, flash, ped_pending, grant_idx);
        end
        rst = 1'b0;
        hold_ack = 1'b0;
        cycle(2);
        checks++;
        if (hold_req !== 1'b0 || ped_pending !== 4'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle actual hold=%b pend=%b required 0 0000",
                     hold_req, ped_pending);
        end
    endtask

    initial begin
        $display("[TB] ped_phase_scheduler bench start");
        test_reset();
        test_two_requests();
        test_round_robin();
        test_mask_during_walk();
        test_single();
        test_abort();
        test_reset_mid_phase();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
